demodulate_param: RTL and testbench

DEMODULATE_PARAM -- requirements
Module: demodulate_param

---
 rtl/demod_pkg.sv | 29 ++
 rtl/demodulate_param_qarctan.sv | 79 +++++++
 rtl/demodulate_param.sv | 161 ++++++++++++++++
 tb/tb_demodulate_param.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// Shared types and fixed-point helpers for the FM demodulator slice.
package demod_pkg;

   // Demodulator control states.
   typedef enum logic [2:0] {
      PRIME,
      PRIME_OUT,
      IDLE,
      MULT,
      DEQU,
      WAITING,
      OUTPUT
   } state_t;

   // Dequantize a 64-bit fixed-point value by 'bits' fraction bits, rounding toward zero.
   function automatic logic signed [63:0] deq(input logic signed [63:0] v,
                                              input int unsigned       bits);
      logic signed [63:0] bias;
      bias = (64'sd1 <<< bits) - 64'sd1;
      return (v < 0) ? ((v + bias) >>> bits) : (v >>> bits);
   endfunction

   // Quantize an integer into fixed point with 'bits' fraction bits.
   function automatic logic signed [63:0] quantize(input logic signed [63:0] v,
                                                   input int unsigned       bits);
      return v <<< bits;
   endfunction

endpackage

// File: rtl/demodulate_param_qarctan.sv
// Quantized arctangent of y/x. Two-stage pipeline: the first stage forms the
// ratio numerator/denominator for the quadrant, the second divides, applies the
// linear approximation and restores the sign. done pulses two cycles after valid.
module qarctan
   import demod_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BITS       = 10
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic signed [DATA_WIDTH-1:0] x,
   input  logic signed [DATA_WIDTH-1:0] y,
   input  logic                         valid,
   output logic signed [DATA_WIDTH-1:0] angle,
   output logic                         done
);

   localparam real PI = 3.14159265358979323846;
   localparam logic signed [63:0] QUAD1 = 64'($rtoi(PI / 4.0 * $itor(1 << BITS)));
   localparam logic signed [63:0] QUAD3 = 64'($rtoi(3.0 * PI / 4.0 * $itor(1 << BITS)));

   logic signed [63:0] xw, yw, abs_y;
   logic signed [63:0] num_c, den_c, base_c;
   logic signed [63:0] num_q, den_q, base_q;
   logic               neg_q, busy;
   logic signed [63:0] ratio, ang;
   logic signed [DATA_WIDTH-1:0] ang_c;

   // Quadrant selection: ratio operands and base angle.
   always_comb begin
      xw    = 64'(x);
      yw    = 64'(y);
      abs_y = yw[63] ? -yw : yw;
      if (!xw[63]) begin
         num_c  = quantize(xw - abs_y, BITS);
         den_c  = xw + abs_y;
         base_c = QUAD1;
      end else begin
         num_c  = quantize(xw + abs_y, BITS);
         den_c  = abs_y - xw;
         base_c = QUAD3;
      end
   end

   // Divide and apply the approximation; x=y=0 yields a zero angle.
   always_comb begin
      ratio = (den_q == '0) ? '0 : (num_q / den_q);
      ang   = base_q - deq(QUAD1 * ratio, BITS);
      ang_c = DATA_WIDTH'(neg_q ? -ang : ang);
   end

   // Pipeline registers and done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         num_q  <= '0;
         den_q  <= '0;
         base_q <= '0;
         neg_q  <= 1'b0;
         busy   <= 1'b0;
         angle  <= '0;
         done   <= 1'b0;
      end else begin
         busy <= valid;
         done <= 1'b0;
         if (valid) begin
            num_q  <= num_c;
            den_q  <= den_c;
            base_q <= base_c;
            neg_q  <= y[DATA_WIDTH-1];
         end
         if (busy) begin
            angle <= ang_c;
            done  <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/demodulate_param.sv
// FM demodulator: reads I/Q pairs from an input FIFO, computes the phase step
// between consecutive samples via conj-multiply and qarctan, scales by GAIN and
// pushes the result to an output FIFO. One sample in flight at a time.
// DATA_WIDTH is limited to 32 so that products fit the 64-bit helpers.
module demodulate_param
   import demod_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int BITS        = 10,
   parameter int GAIN        = 'h2F6,
   parameter int PRIME_VALUE = 'h4A6,
   parameter bit PRIME_EN    = 1'b1
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         fifo_in_empty,
   output logic                         rd_en_in,
   input  logic signed [DATA_WIDTH-1:0] real_in,
   input  logic signed [DATA_WIDTH-1:0] imag_in,
   output logic signed [DATA_WIDTH-1:0] demod_out,
   output logic                         wr_en_out,
   input  logic                         fifo_out_full,
   output logic [31:0]                  sample_count
);

   state_t state;

   logic signed [DATA_WIDTH-1:0]   prev_r, prev_i, curr_r, curr_i;
   logic signed [2*DATA_WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [DATA_WIDTH-1:0]   x, y;
   logic                           demod_valid_in;
   logic                           flush_pend;

   logic signed [DATA_WIDTH-1:0]   qarctan_out;
   logic                           qarctan_done;

   logic signed [DATA_WIDTH-1:0]   x_c, y_c, demod_c;

   qarctan #(
      .DATA_WIDTH (DATA_WIDTH),
      .BITS       (BITS)
   ) u_qarctan (
      .clock (clock),
      .reset (reset),
      .x     (x),
      .y     (y),
      .valid (demod_valid_in),
      .angle (qarctan_out),
      .done  (qarctan_done)
   );

   // Dequantized conj-product terms and the scaled output sample.
   always_comb begin
      x_c     = DATA_WIDTH'(deq(64'(p_rr), BITS) + deq(64'(p_ii), BITS));
      y_c     = DATA_WIDTH'(deq(64'(p_ri), BITS) - deq(64'(p_ir), BITS));
      demod_c = DATA_WIDTH'(deq(64'(qarctan_out) * 64'(GAIN), BITS));
   end

   // Control FSM with registered strobes. A read is never issued while the
   // previous rd_en_in pulse is still outstanding, since the FIFO head only
   // advances on the edge that consumes that pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state          <= PRIME;
         prev_r         <= '0;
         prev_i         <= '0;
         curr_r         <= '0;
         curr_i         <= '0;
         p_rr           <= '0;
         p_ii           <= '0;
         p_ri           <= '0;
         p_ir           <= '0;
         x              <= '0;
         y              <= '0;
         demod_out      <= '0;
         rd_en_in       <= 1'b0;
         wr_en_out      <= 1'b0;
         sample_count   <= '0;
         demod_valid_in <= 1'b0;
         flush_pend     <= 1'b0;
      end else begin
         rd_en_in       <= 1'b0;
         wr_en_out      <= 1'b0;
         demod_valid_in <= 1'b0;
         if (flush && state != IDLE && state != PRIME)
            flush_pend <= 1'b1;

         unique case (state)
            PRIME: begin
               if (flush) begin
                  prev_r     <= '0;
                  prev_i     <= '0;
                  flush_pend <= 1'b0;
               end else if (!fifo_in_empty && !rd_en_in) begin
                  rd_en_in <= 1'b1;
                  prev_r   <= real_in;
                  prev_i   <= imag_in;
                  if (PRIME_EN) begin
                     demod_out <= DATA_WIDTH'(PRIME_VALUE);
                     state     <= PRIME_OUT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            PRIME_OUT: begin
               demod_out <= DATA_WIDTH'(PRIME_VALUE);
               if (!fifo_out_full) begin
                  wr_en_out    <= 1'b1;
                  sample_count <= sample_count + 32'd1;
                  state        <= IDLE;
               end
            end
            IDLE: begin
               if (flush || flush_pend) begin
                  prev_r     <= '0;
                  prev_i     <= '0;
                  flush_pend <= 1'b0;
                  state      <= PRIME;
               end else if (!fifo_in_empty && !rd_en_in) begin
                  rd_en_in <= 1'b1;
                  curr_r   <= real_in;
                  curr_i   <= imag_in;
                  state    <= MULT;
               end
            end
            MULT: begin
               p_rr  <= prev_r * curr_r;
               p_ii  <= prev_i * curr_i;
               p_ri  <= prev_r * curr_i;
               p_ir  <= prev_i * curr_r;
               state <= DEQU;
            end
            DEQU: begin
               x              <= x_c;
               y              <= y_c;
               demod_valid_in <= 1'b1;
               state          <= WAITING;
            end
            WAITING: begin
               if (qarctan_done) begin
                  demod_out <= demod_c;
                  state     <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (!fifo_out_full) begin
                  wr_en_out    <= 1'b1;
                  prev_r       <= curr_r;
                  prev_i       <= curr_i;
                  sample_count <= sample_count + 32'd1;
                  state        <= IDLE;
               end
            end
            default: state <= PRIME;
         endcase
      end
   end

endmodule

// File: tb/tb_demodulate_param.sv
// Directed bench for demodulate_param: one instance with priming output enabled
// and one with it disabled, each fed from a queue-modelled input FIFO.
module tb_demodulate_param;
   import demod_pkg::*;

   typedef struct packed {
      logic signed [31:0] re;
      logic signed [31:0] im;
   } pair_t;

   typedef struct {
      int re;
      int im;
      int exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   logic               flush_a, empty_a, rd_a, wr_a, full_a;
   logic signed [31:0] re_a, im_a, demod_a;
   logic [31:0]        cnt_a;

   logic               flush_b, empty_b, rd_b, wr_b, full_b;
   logic signed [31:0] re_b, im_b, demod_b;
   logic [31:0]        cnt_b;

   pair_t              qa[$], qb[$];
   logic signed [31:0] oa[$], ob[$];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   demodulate_param dut_a (
      .clock         (clk),
      .reset         (rst),
      .flush         (flush_a),
      .fifo_in_empty (empty_a),
      .rd_en_in      (rd_a),
      .real_in       (re_a),
      .imag_in       (im_a),
      .demod_out     (demod_a),
      .wr_en_out     (wr_a),
      .fifo_out_full (full_a),
      .sample_count  (cnt_a)
   );

   demodulate_param #(.PRIME_EN(1'b0)) dut_b (
      .clock         (clk),
      .reset         (rst),
      .flush         (flush_b),
      .fifo_in_empty (empty_b),
      .rd_en_in      (rd_b),
      .real_in       (re_b),
      .imag_in       (im_b),
      .demod_out     (demod_b),
      .wr_en_out     (wr_b),
      .fifo_out_full (full_b),
      .sample_count  (cnt_b)
   );

   // FIFO models: pop on read strobe, capture on write strobe.
   always @(posedge clk) begin
      if (rd_a && qa.size() > 0) void'(qa.pop_front());
      if (rd_b && qb.size() > 0) void'(qb.pop_front());
      if (wr_a) oa.push_back(demod_a);
      if (wr_b) ob.push_back(demod_b);
   end

   // Protocol checks, then present the new FIFO heads.
   always @(negedge clk) begin
      if (rd_a && empty_a) begin
         miscompares++;
         $display("FAIL rd_while_empty_a: rd_en_in=1 expected 0 while empty");
      end
      if (rd_b && empty_b) begin
         miscompares++;
         $display("FAIL rd_while_empty_b: rd_en_in=1 expected 0 while empty");
      end
      if (wr_a && full_a) begin
         miscompares++;
         $display("FAIL wr_while_full_a: wr_en_out=1 expected 0 while full");
      end
      empty_a = (qa.size() == 0);
      re_a    = empty_a ? 32'sd0 : qa[0].re;
      im_a    = empty_a ? 32'sd0 : qa[0].im;
      empty_b = (qb.size() == 0);
      re_b    = empty_b ? 32'sd0 : qb[0].re;
      im_b    = empty_b ? 32'sd0 : qb[0].im;
   end

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait (bounded) for the next write from instance A.
   task automatic get_a(input string name, output logic signed [31:0] v);
      int t = 0;
      while (oa.size() == 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (oa.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: got no write expected one within 200 cycles", name);
         v = '0;
      end else begin
         v = oa.pop_front();
      end
   endtask

   vec_t               tbl[8];
   logic signed [31:0] v;
   bit                 stable;

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1);
   end

   initial begin
      rst     = 1'b1;
      flush_a = 1'b0;
      full_a  = 1'b0;
      flush_b = 1'b0;
      full_b  = 1'b0;
      empty_a = 1'b1;
      empty_b = 1'b1;
      re_a = '0; im_a = '0; re_b = '0; im_b = '0;

      // Stream continuing from prime pair (1024,0): {re, im, expected output}.
      tbl[0] = '{1024, 0, 0};
      tbl[1] = '{0, 1024, 1190};
      tbl[2] = '{-1024, 0, 1190};
      tbl[3] = '{0, -1024, 1190};
      tbl[4] = '{-1024, 0, -1190};
      tbl[5] = '{1024, 0, 2380};
      tbl[6] = '{1024, 1024, 595};
      tbl[7] = '{3, -2, -991};

      qa.push_back('{re: 32'sd1024, im: 32'sd0});
      qb.push_back('{re: 32'sd1024, im: 32'sd0});
      qb.push_back('{re: 32'sd1024, im: 32'sd0});
      qb.push_back('{re: 32'sd0, im: 32'sd1024});

      repeat (3) @(negedge clk);
      check("reset_rd_en", rd_a, 0);
      check("reset_wr_en", wr_a, 0);
      check("reset_demod", demod_a, 0);
      check("reset_count", cnt_a, 0);
      check("reset_rd_en_b", rd_b, 0);
      check("reset_count_b", cnt_b, 0);
      rst = 1'b0;

      // Priming sample emits PRIME_VALUE exactly once.
      get_a("prime_out", v);
      check("prime_out", v, 'h4A6);
      repeat (10) @(negedge clk);
      check("prime_count", cnt_a, 1);
      check("prime_single", oa.size(), 0);

      for (int i = 0; i < 8; i++) begin
         qa.push_back('{re: 32'(tbl[i].re), im: 32'(tbl[i].im)});
         get_a($sformatf("vec%0d", i), v);
         check($sformatf("vec%0d", i), v, tbl[i].exp);
      end
      check("count_after_table", cnt_a, 9);

      check("deq_neg1500", deq(-64'sd1500, 10), -1);
      check("deq_pos1500", deq(64'sd1500, 10), 1);
      check("deq_neg1", deq(-64'sd1, 10), 0);

      // Output stall: result (3,-2)->(1024,0) held while full.
      full_a = 1'b1;
      qa.push_back('{re: 32'sd1024, im: 32'sd0});
      repeat (10) @(negedge clk);
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wr_a || demod_a !== 32'sd476) stable = 1'b0;
      end
      check("stall_hold", stable, 1);
      check("stall_no_write", oa.size(), 0);
      full_a = 1'b0;
      get_a("stall_release", v);
      check("stall_release", v, 476);
      repeat (10) @(negedge clk);
      check("stall_single", oa.size(), 0);

      // Flush raised while the sample is in qarctan.
      qa.push_back('{re: 32'sd1024, im: 32'sd0});
      begin
         int t = 0;
         while (!rd_a && t < 50) begin
            @(negedge clk);
            t++;
         end
         check("flush_saw_read", rd_a, 1);
      end
      repeat (2) @(negedge clk);
      flush_a = 1'b1;
      @(negedge clk);
      flush_a = 1'b0;
      qa.push_back('{re: 32'sd0, im: 32'sd1024});
      get_a("flush_inflight", v);
      check("flush_inflight", v, 0);
      get_a("flush_reprime", v);
      check("flush_reprime", v, 'h4A6);
      qa.push_back('{re: 32'sd1024, im: 32'sd0});
      get_a("after_reprime", v);
      check("after_reprime", v, -1190);

      // Flush and data together in IDLE: flush wins, sample becomes a prime.
      flush_a = 1'b1;
      qa.push_back('{re: 32'sd1024, im: 32'sd0});
      @(negedge clk);
      flush_a = 1'b0;
      get_a("idle_flush_prime", v);
      check("idle_flush_prime", v, 'h4A6);
      repeat (10) @(negedge clk);
      check("final_count", cnt_a, 14);
      check("no_extra_writes", oa.size(), 0);

      // PRIME_EN=0 instance: three pairs give two outputs.
      check("noprime_writes", ob.size(), 2);
      if (ob.size() == 2) begin
         check("noprime_out0", ob[0], 0);
         check("noprime_out1", ob[1], 1190);
      end
      check("noprime_count", cnt_b, 2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
